cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache that serve the pipeline's instruction port (a) and data port (b).
- Merges their cache-line miss/writeback traffic onto the single line-wide port of the L2 cache / physical memory.
- Grants one transaction at a time, using round-robin when both requesters are pending.
- Registers the granted request and the returned line, and pulses a one-cycle response back to the owning requester.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits; mem_address low log2(LINE_WIDTH/8) bits are forced to 0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  registered line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  writeback line
- d_rdata  out  LINE_WIDTH  registered line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  downstream read, held until mem_resp
- mem_write  out  1  downstream write, held until mem_resp
- mem_address  out  ADDR_WIDTH  downstream line-aligned address
- mem_wdata  out  LINE_WIDTH  downstream write line
- mem_rdata  in  LINE_WIDTH  downstream read line, valid with mem_resp
- mem_resp  in  1  downstream completion, one cycle

Behaviour:
- Single clock. Reset is synchronous, active-high.
- On rst: state=IDLE; last_grant=I, so D wins the first tie; mem_read, mem_write, i_resp, d_resp all 0; mem_address, mem_wdata, i_rdata, d_rdata all 0.
- States are IDLE, BUSY, RESP. All outputs come from registers; there is no combinational path from inputs to outputs.
- IDLE:
  - Pending I = i_read. Pending D = d_read|d_write.
  - Neither pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: grant the requester not equal to last_grant.
  - On grant, latch grant, address (low bits zeroed), d_wdata and op, update last_grant, and go to BUSY.
  - Op for an I grant is always read.
  - Op for a D grant: d_write=1 gives write (d_write wins if d_read is also high); otherwise read.
- BUSY:
  - Drive mem_read or mem_write (exactly one) from the latched op.
  - Drive mem_address and mem_wdata from the latches.
  - Hold until mem_resp.
  - On mem_resp, for a read, capture mem_rdata into i_rdata or d_rdata per grant; a write leaves d_rdata unchanged. Deassert mem_read/mem_write the next cycle and go to RESP.
- RESP:
  - Assert i_resp or d_resp for exactly one cycle; i_rdata/d_rdata are valid in this cycle and held afterwards until the next capture.
  - Return to IDLE. A request still high during RESP is not sampled; it is sampled again in IDLE next cycle.
- Latency: request seen in IDLE cycle t gives mem_* asserted in t+1. mem_resp in cycle t+k (k≥1) gives resp in t+k+1. The minimum is 3 cycles. Back-to-back transactions have at least 1 IDLE cycle between resp and the next mem_* assertion.
- Requester inputs may change while BUSY; latched values are used and the transaction completes, and resp still pulses even if the request has dropped.
- mem_resp outside BUSY is ignored.
- rst mid-transaction: back to IDLE and all outputs 0 next cycle; the in-flight downstream transaction is abandoned (downstream is reset with it).
- Starvation-free: with both requesters continuously pending, grants alternate I/D.

Decomposition:
- Package arbiter_types holds:
  - enum arb_state_t {IDLE, BUSY, RESP}
  - enum arb_grant_t {GRANT_I, GRANT_D}
  - localparam LINE_OFFSET_BITS = $clog2(LINE_WIDTH/8)
- No sub-module is needed. The latch bank reuses the existing generic register module, parameterized by width.

Test Plan:
1. Reset, then i_read=1, i_address=0x0000_0064; memory answers mem_resp 2 cycles after mem_read with line 0xAAAA…A → mem_address=0x0000_0060, mem_read=1 from cycle 1, i_resp single pulse with i_rdata=0xAAAA…A, d_resp stays 0.
2. d_write=1, d_address=0x8000_001F, d_wdata=0x1234…; mem_resp after 1 cycle → mem_write=1, mem_read=0, mem_address=0x8000_0000, mem_wdata=0x1234…, d_resp pulse, d_rdata unchanged.
3. i_read and d_read both asserted from reset and held continuously → grant order D, I, D, I; each resp is exactly one cycle; never both resp high.
4. Grant D read, drop d_read while BUSY, then mem_resp → transaction completes, d_resp still pulses, no new request issued.
5. rst asserted in BUSY with mem_read=1 → next cycle state is IDLE, mem_read=0, no resp; a fresh i_read afterwards completes normally.
6. mem_resp pulsed while IDLE, and d_read and d_write both high → the stray mem_resp produces no output change; the dual request issues mem_write only.

Source files
------------

// File: rtl/arbiter_types.sv
// Shared types for the I/D cache-to-memory arbiter.
//   arb_state_t      : IDLE / BUSY / RESP transaction phases
//   arb_grant_t      : owner of the current transaction
//   LINE_OFFSET_BITS : byte-offset bits of a default-width cache line
//   line_offset_bits : the same value for any line width
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    localparam int unsigned LINE_WIDTH_DEFAULT = 256;
    localparam int unsigned LINE_OFFSET_BITS   = $clog2(LINE_WIDTH_DEFAULT / 8);

    function automatic int unsigned line_offset_bits(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/cache_arbiter_reg.sv
// Generic enabled register with synchronous active-high clear.
//   clk, rst : clock and synchronous reset (clears q to zero)
//   en       : load enable
//   d / q    : WIDTH-bit data in / registered data out
module cache_arbiter_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line traffic onto one
// line-wide L2/memory port. One transaction in flight; all outputs registered.
//   clk, rst                      : clock, synchronous active-high reset
//   i_read, i_address             : I-cache line read request (held until i_resp)
//   i_rdata, i_resp               : returned line and one-cycle completion to I-cache
//   d_read, d_write, d_address,
//   d_wdata                       : D-cache line read / writeback request (held until d_resp)
//   d_rdata, d_resp               : returned line and one-cycle completion to D-cache
//   mem_read, mem_write,
//   mem_address, mem_wdata        : downstream request, held until mem_resp
//   mem_rdata, mem_resp           : downstream read line and completion
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int unsigned OFFSET_BITS = line_offset_bits(LINE_WIDTH);
    localparam int unsigned REQ_WIDTH   = ADDR_WIDTH + LINE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    arb_state_t state, state_next;
    arb_grant_t grant, grant_next;
    arb_grant_t last_grant, last_grant_next;

    logic mem_read_next, mem_write_next;
    logic i_resp_next, d_resp_next;
    logic req_load, i_capture, d_capture;
    logic pend_i, pend_d, pick_d;

    logic [ADDR_WIDTH-1:0] sel_address;
    logic [ADDR_WIDTH-1:0] aligned_address;
    logic [REQ_WIDTH-1:0]  req_q;

    // Round-robin pick: D wins when alone, or on a tie when I was served last.
    assign pend_i          = i_read;
    assign pend_d          = d_read | d_write;
    assign pick_d          = pend_d && (!pend_i || (last_grant == GRANT_I));
    assign sel_address     = pick_d ? d_address : i_address;
    assign aligned_address = sel_address & ~OFFSET_MASK;

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GRANT_I;
            last_grant <= GRANT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            mem_read   <= mem_read_next;
            mem_write  <= mem_write_next;
            i_resp     <= i_resp_next;
            d_resp     <= d_resp_next;
        end
    end

    // Next-state and register-update decode
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        mem_read_next   = mem_read;
        mem_write_next  = mem_write;
        i_resp_next     = 1'b0;
        d_resp_next     = 1'b0;
        req_load        = 1'b0;
        i_capture       = 1'b0;
        d_capture       = 1'b0;

        unique case (state)
            IDLE: begin
                if (pend_i || pend_d) begin
                    grant_next      = pick_d ? GRANT_D : GRANT_I;
                    last_grant_next = pick_d ? GRANT_D : GRANT_I;
                    req_load        = 1'b1;
                    // A D writeback takes precedence over a simultaneous D read.
                    mem_write_next  = pick_d && d_write;
                    mem_read_next   = !(pick_d && d_write);
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    i_capture      = mem_read && (grant == GRANT_I);
                    d_capture      = mem_read && (grant == GRANT_D);
                    i_resp_next    = (grant == GRANT_I);
                    d_resp_next    = (grant == GRANT_D);
                    state_next     = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Granted address and writeback line, held for the whole transaction
    cache_arbiter_reg #(.WIDTH(REQ_WIDTH)) u_req_reg (
        .clk (clk),
        .rst (rst),
        .en  (req_load),
        .d   ({aligned_address, d_wdata}),
        .q   (req_q)
    );

    assign mem_address = req_q[REQ_WIDTH-1 -: ADDR_WIDTH];
    assign mem_wdata   = req_q[LINE_WIDTH-1:0];

    // Returned lines, held until the next read for the same requester
    cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_i_rdata_reg (
        .clk (clk),
        .rst (rst),
        .en  (i_capture),
        .d   (mem_rdata),
        .q   (i_rdata)
    );

    cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_d_rdata_reg (
        .clk (clk),
        .rst (rst),
        .en  (d_capture),
        .d   (mem_rdata),
        .q   (d_rdata)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: requester drivers push expected
// transactions, a memory responder answers downstream requests, and a
// monitor checks grant order, downstream fields and responses.
module tb_cache_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            pcyc;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    req_t          exp_i[$];
    req_t          exp_d[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_resp_cyc = -10;
    bit            mem_auto = 1'b1;
    int            fix_dly = -1;
    bit            stray_req = 1'b0;
    bit            prev_owner_d = 1'b0;
    bit            owner_d = 1'b0;
    bit            prev_op = 1'b0;
    logic [LW-1:0] last_d_rdata = '0;
    logic [LW-1:0] saved_i, saved_d;

    bit m_op, m_due, m_pi, m_pd, m_want_d, m_ei, m_ed;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    // Memory contents: a fixed pattern derived from the line address
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < int'(LW / 32); k++) begin
            l[k*32 +: 32] = a ^ (32'h0101_0101 * k) ^ 32'hA5A5_5A5A;
        end
        return l;
    endfunction

    function automatic void chk_b(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void chk_w(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream memory responder
    initial begin
        int cnt;
        int dly;
        cnt = 0;
        dly = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            if (stray_req && !(mem_read || mem_write)) begin
                mem_resp = 1'b1;
                mem_rdata = {8{$urandom}};
                stray_req = 1'b0;
            end else if (mem_auto && (mem_read || mem_write)) begin
                if (cnt == 0) dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                if (cnt == dly) begin
                    mem_resp = 1'b1;
                    mem_rdata = mem_read ? line_of(mem_address) : {8{$urandom}};
                    last_resp_cyc = cyc;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: grant order, downstream request fields, responses
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_op = 1'b0;
        end else begin
            m_op  = mem_read | mem_write;
            m_due = (last_resp_cyc == cyc - 1);
            if (m_op && !prev_op) begin
                // requests visible when the arbiter sampled them, one cycle ago
                m_pi = (exp_i.size() > 0) && (exp_i[0].pcyc <= cyc - 1);
                m_pd = (exp_d.size() > 0) && (exp_d[0].pcyc <= cyc - 1);
                chk_b("op_has_pending_req", m_pi | m_pd, 1'b1);
                if (m_pi || m_pd) begin
                    m_want_d     = m_pd && (!m_pi || !prev_owner_d);
                    owner_d      = m_want_d;
                    prev_owner_d = m_want_d;
                    if (m_want_d) begin
                        chk_b("d_mem_write", mem_write, exp_d[0].wr);
                        chk_b("d_mem_read", mem_read, !exp_d[0].wr);
                        chk_w("d_mem_address", LW'(mem_address), LW'(align(exp_d[0].addr)));
                        if (exp_d[0].wr) chk_w("d_mem_wdata", mem_wdata, exp_d[0].wdata);
                    end else begin
                        chk_b("i_mem_read", mem_read, 1'b1);
                        chk_b("i_mem_write", mem_write, 1'b0);
                        chk_w("i_mem_address", LW'(mem_address), LW'(align(exp_i[0].addr)));
                    end
                end
            end else if (prev_op) begin
                // request holds until mem_resp, then drops
                chk_b("mem_hold", m_op, !m_due);
            end
            if (m_due || i_resp || d_resp) begin
                m_ei = m_due && !owner_d;
                m_ed = m_due && owner_d;
                chk_b("i_resp", i_resp, m_ei);
                chk_b("d_resp", d_resp, m_ed);
                if (m_ei && exp_i.size() > 0) begin
                    chk_w("i_rdata", i_rdata, exp_i[0].rdata);
                    void'(exp_i.pop_front());
                end
                if (m_ed && exp_d.size() > 0) begin
                    if (exp_d[0].wr) begin
                        chk_w("d_rdata_kept", d_rdata, last_d_rdata);
                    end else begin
                        chk_w("d_rdata", d_rdata, exp_d[0].rdata);
                        last_d_rdata = exp_d[0].rdata;
                    end
                    void'(exp_d.pop_front());
                end
            end
            prev_op = m_op;
        end
    end

    task automatic push_i(input logic [AW-1:0] a);
        req_t r;
        r.wr = 1'b0; r.addr = a; r.wdata = '0; r.rdata = line_of(align(a)); r.pcyc = cyc;
        i_address = a;
        i_read = 1'b1;
        exp_i.push_back(r);
    endtask

    task automatic push_d(input bit wr, input bit both, input logic [AW-1:0] a, input logic [LW-1:0] w);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = w; r.rdata = line_of(align(a)); r.pcyc = cyc;
        d_address = a;
        d_wdata = w;
        d_write = wr;
        d_read = !wr || both;
        exp_d.push_back(r);
    endtask

    task automatic wait_resp(input bit is_d);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(is_d ? d_resp : i_resp) && n < 80);
        if (is_d) begin
            chk_b("d_resp_seen", d_resp, 1'b1);
            d_read = 1'b0;
            d_write = 1'b0;
        end else begin
            chk_b("i_resp_seen", i_resp, 1'b1);
            i_read = 1'b0;
        end
    endtask

    task automatic wait_mem_op();
        int n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_b("mem_op_seen", mem_read | mem_write, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_i.size() + exp_d.size()) != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_w("queues_drained", LW'(exp_i.size() + exp_d.size()), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_i.delete();
        exp_d.delete();
        prev_owner_d = 1'b0;
        last_d_rdata = '0;
    endtask

    task automatic drive_i(input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            push_i($urandom);
            wait_resp(1'b0);
        end
    endtask

    task automatic drive_d(input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            push_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, {8{$urandom}});
            wait_resp(1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0;
        i_address = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = '0;
        d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk_b("rst_mem_read", mem_read, 1'b0);
        chk_b("rst_mem_write", mem_write, 1'b0);
        chk_b("rst_i_resp", i_resp, 1'b0);
        chk_b("rst_d_resp", d_resp, 1'b0);
        chk_w("rst_mem_address", LW'(mem_address), '0);
        chk_w("rst_mem_wdata", mem_wdata, '0);
        chk_w("rst_i_rdata", i_rdata, '0);
        chk_w("rst_d_rdata", d_rdata, '0);

        // single I read with line-offset address bits
        @(posedge clk);
        #1;
        fix_dly = 2;
        push_i(32'h0000_0064);
        @(negedge clk);
        chk_b("t1_mem_read_idle", mem_read, 1'b0);
        @(negedge clk);
        chk_b("t1_mem_read_next", mem_read, 1'b1);
        chk_w("t1_mem_address", LW'(mem_address), LW'(32'h0000_0060));
        wait_resp(1'b0);
        wait_idle();

        // D writeback
        fix_dly = 1;
        push_d(1'b1, 1'b0, 32'h8000_001F, {8{32'h1234_5678}});
        wait_resp(1'b1);
        wait_idle();

        // both continuously pending from reset: D first, then alternate
        fix_dly = -1;
        do_reset();
        fork
            drive_i(4, 0);
            drive_d(4, 0);
        join
        wait_idle();

        // D read dropped while busy still completes
        push_d(1'b0, 1'b0, $urandom, '0);
        wait_mem_op();
        d_read = 1'b0;
        wait_resp(1'b1);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;

        // reset while a read is outstanding
        mem_auto = 1'b0;
        push_i($urandom);
        wait_mem_op();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_read = 1'b0;
        exp_i.delete();
        exp_d.delete();
        prev_owner_d = 1'b0;
        last_d_rdata = '0;
        @(negedge clk);
        chk_b("t5_mem_read_after_rst", mem_read, 1'b0);
        chk_b("t5_i_resp_after_rst", i_resp, 1'b0);
        chk_w("t5_i_rdata_after_rst", i_rdata, '0);
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        push_i($urandom);
        wait_resp(1'b0);
        wait_idle();

        // stray mem_resp in IDLE, then read+write together issues a write
        repeat (2) @(posedge clk);
        #1;
        saved_i = i_rdata;
        saved_d = d_rdata;
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_w("t6_i_rdata_stable", i_rdata, saved_i);
        chk_w("t6_d_rdata_stable", d_rdata, saved_d);
        push_d(1'b1, 1'b1, $urandom, {8{$urandom}});
        wait_resp(1'b1);
        wait_idle();

        // randomized mixed traffic
        do_reset();
        fork
            drive_i(25, 3);
            drive_d(25, 3);
        join
        wait_idle();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
